// File: rtl/dbus_responder_if.sv
// rtl/dbus_responder_if.sv - memory-stage data bus and TX byte stream bundle for dbus_responder
interface dbus_responder_if;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] BM;
    logic [31:0] ReadDataM;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [31:0] gpio_out;

    // core memory stage plus stream consumer
    modport master (
        output MemWriteM, ALUResultM, BM, tx_ready,
        input  ReadDataM, tx_valid, tx_data, gpio_out
    );

    // the responder
    modport slave (
        input  MemWriteM, ALUResultM, BM, tx_ready,
        output ReadDataM, tx_valid, tx_data, gpio_out
    );
endinterface

// File: rtl/dbus_responder.sv
// rtl/dbus_responder.sv - data-side RAM + MMIO responder with TX byte FIFO (optional DBUS_MISALIGN_CHECK_EN)
module dbus_responder #(
    parameter int         RAM_WORDS   = 256,
    parameter int         FIFO_DEPTH  = 8,
    parameter logic [3:0] MMIO_NIBBLE = 4'h8
) (
    input  logic            clk,
    input  logic            rst,
    dbus_responder_if.slave bus
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CYCLE  = 2'd2;
    localparam logic [1:0] OFF_GPIO   = 2'd3;

    logic [31:0]   mem_q  [RAM_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   cycle_q, cycle_d;
    logic [31:0]   gpio_q, gpio_d;
    logic          mis_bit;

    logic          mmio_sel;
    logic          misaligned;
    logic          wr_ok;
    logic          ram_we;
    logic          reg_we;
    logic [1:0]    reg_off;
    logic [AW-1:0] ram_idx;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_req;
    logic          push;
    logic [31:0]   status_word;
    logic [31:0]   rdata;

    // address bits that only alias; gathered so they are visibly consumed
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.ALUResultM[27:AW+2], bus.ALUResultM[1:0]};

    assign mmio_sel = (bus.ALUResultM[31:28] == MMIO_NIBBLE);
    assign reg_off  = bus.ALUResultM[3:2];
    assign ram_idx  = bus.ALUResultM[AW+1:2];

`ifdef DBUS_MISALIGN_CHECK_EN
    assign misaligned = (bus.ALUResultM[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign wr_ok    = bus.MemWriteM && !misaligned;
    assign ram_we   = wr_ok && !mmio_sel;
    assign reg_we   = wr_ok && mmio_sel;

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign pop      = !empty && bus.tx_ready;
    assign push_req = reg_we && (reg_off == OFF_TXDATA);
    // a full FIFO still takes a byte when the head leaves on the same edge
    assign push     = push_req && (!full || pop);

    assign status_word = {23'd0, 5'(count_q), mis_bit, ovf_q, empty, full};

    // next-state for FIFO bookkeeping and MMIO registers
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        cycle_d  = cycle_q + 32'd1;
        gpio_d   = gpio_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        // clear first so a coincident new overflow wins
        if (reg_we && (reg_off == OFF_STATUS) && bus.BM[2]) begin
            ovf_d = 1'b0;
        end
        if (push_req && !push) begin
            ovf_d = 1'b1;
        end
        if (reg_we && (reg_off == OFF_CYCLE)) begin
            cycle_d = bus.BM;
        end
        if (reg_we && (reg_off == OFF_GPIO)) begin
            gpio_d = bus.BM;
        end
    end

    // control/status registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            cycle_q  <= '0;
            gpio_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            cycle_q  <= cycle_d;
            gpio_q   <= gpio_d;
        end
    end

`ifdef DBUS_MISALIGN_CHECK_EN
    logic mis_q, mis_d;

    // sticky misaligned-write flag; a misaligned write can never be the clearing STATUS write
    always_comb begin
        mis_d = mis_q;
        if (reg_we && (reg_off == OFF_STATUS) && bus.BM[3]) begin
            mis_d = 1'b0;
        end
        if (bus.MemWriteM && misaligned) begin
            mis_d = 1'b1;
        end
    end

    // misaligned sticky flop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign mis_bit = mis_q;
`else
    assign mis_bit = 1'b0;
`endif

    // RAM word write; storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[ram_idx] <= bus.BM;
        end
    end

    // FIFO byte storage; only the occupied slots are ever observed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= bus.BM[7:0];
        end
    end

    // same-cycle read mux; RAM shows the pre-write word during a write
    always_comb begin
        rdata = 32'd0;
        if (!misaligned) begin
            if (mmio_sel) begin
                case (reg_off)
                    OFF_TXDATA: rdata = 32'd0;
                    OFF_STATUS: rdata = status_word;
                    OFF_CYCLE:  rdata = cycle_q;
                    default:    rdata = gpio_q;
                endcase
            end else begin
                rdata = mem_q[ram_idx];
            end
        end
    end

    assign bus.ReadDataM = rdata;
    assign bus.tx_valid  = !empty;
    assign bus.tx_data   = empty ? 8'd0 : fifo_q[rd_ptr_q];
    assign bus.gpio_out  = gpio_q;
endmodule

// File: tb/tb_dbus_responder.sv
// tb/tb_dbus_responder.sv - randomized bench with behavioural model for dbus_responder
module tb_dbus_responder;
`ifdef DBUS_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif
    localparam logic [31:0] A_TX     = 32'h8000_0000;
    localparam logic [31:0] A_STATUS = 32'h8000_0004;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0008;
    localparam logic [31:0] A_GPIO   = 32'h8000_000C;

    logic clk;
    logic rst;
    dbus_responder_if bus ();

    dbus_responder #(
        .RAM_WORDS   (256),
        .FIFO_DEPTH  (8),
        .MMIO_NIBBLE (4'h8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // behavioural model state
    logic [31:0] m_ram   [256];
    bit          m_known [256];
    logic [7:0]  m_q[$];
    bit          m_ovf;
    bit          m_mis;
    logic [31:0] m_cyc;
    logic [31:0] m_gpio;

    bit          collect;
    logic [7:0]  drained[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit is_mis(input logic [31:0] a);
        return MIS_EN && (a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        int n;
        n = m_q.size();
        s = 32'd0;
        s[0]   = (n == 8);
        s[1]   = (n == 0);
        s[2]   = m_ovf;
        s[3]   = m_mis;
        s[8:4] = 5'(n);
        return s;
    endfunction

    // what a read of address a must return; known=0 when RAM word never written
    task automatic model_read(input logic [31:0] a, output logic [31:0] v, output bit known);
        known = 1'b1;
        v = 32'd0;
        if (is_mis(a)) begin
            v = 32'd0;
        end else if (a[31:28] == 4'h8) begin
            case (a[3:2])
                2'd0: v = 32'd0;
                2'd1: v = model_status();
                2'd2: v = m_cyc;
                default: v = m_gpio;
            endcase
        end else begin
            known = m_known[a[9:2]];
            v = m_ram[a[9:2]];
        end
    endtask

    task automatic model_clock(input bit we, input logic [31:0] a, input logic [31:0] d, input bit rdy);
        bit mis, ok, mm, pop, was_full;
        mis = is_mis(a);
        ok = we && !mis;
        mm = (a[31:28] == 4'h8);
        was_full = (m_q.size() == 8);
        pop = (m_q.size() > 0) && rdy;
        m_cyc = m_cyc + 32'd1;
        if (pop) void'(m_q.pop_front());
        if (ok && mm) begin
            case (a[3:2])
                2'd0: begin
                    if (!was_full || pop) m_q.push_back(d[7:0]);
                    else m_ovf = 1'b1;
                end
                2'd1: begin
                    if (d[2]) m_ovf = 1'b0;
                    if (d[3]) m_mis = 1'b0;
                end
                2'd2: m_cyc = d;
                default: m_gpio = d;
            endcase
        end
        if (we && mis) m_mis = 1'b1;
        if (ok && !mm) begin
            m_ram[a[9:2]] = d;
            m_known[a[9:2]] = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf  = 1'b0;
        m_mis  = 1'b0;
        m_cyc  = 32'd0;
        m_gpio = 32'd0;
    endtask

    // one bus cycle: drive, compare against the model mid-cycle, clock, advance the model
    task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d, input bit rdy,
                        output logic [31:0] rd);
        logic [31:0] ev;
        bit kn;
        bus.MemWriteM  = we;
        bus.ALUResultM = a;
        bus.BM         = d;
        bus.tx_ready   = rdy;
        #3;
        rd = bus.ReadDataM;
        model_read(a, ev, kn);
        if (kn) chk("ReadDataM", rd, ev);
        chk("tx_valid", 32'(bus.tx_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) chk("tx_data", 32'(bus.tx_data), 32'(m_q[0]));
        chk("gpio_out", bus.gpio_out, m_gpio);
        if (collect && bus.tx_valid && rdy) drained.push_back(bus.tx_data);
        @(posedge clk);
        model_clock(we, a, d, rdy);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.MemWriteM = 1'b0;
        #1;
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_gpio", bus.gpio_out, 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] rd, v1;
        logic [7:0]  exp_drain [8];
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
        collect = 1'b0;
        bus.MemWriteM  = 1'b0;
        bus.ALUResultM = A_STATUS;
        bus.BM         = 32'd0;
        bus.tx_ready   = 1'b0;
        rst = 1'b0;
        model_reset();
        #2;
        chk("init_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("init_gpio", bus.gpio_out, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // reset state and cycle counter spacing
        step(0, A_STATUS, 0, 0, rd);
        chk("status_after_reset", rd, 32'h0000_0002);
        step(0, A_CYCLE, 0, 0, v1);
        step(0, A_STATUS, 0, 0, rd);
        step(0, A_STATUS, 0, 0, rd);
        step(0, A_CYCLE, 0, 0, rd);
        chk("cycle_delta", rd - v1, 32'd3);

        // RAM write, old value during write, alias
        step(1, 32'h0000_0010, 32'h1111_1111, 0, rd);
        step(1, 32'h0000_0010, 32'hDEAD_BEEF, 0, rd);
        chk("ram_prewrite", rd, 32'h1111_1111);
        step(0, 32'h0000_0010, 0, 0, rd);
        chk("ram_read", rd, 32'hDEAD_BEEF);
        step(0, 32'h0000_0410, 0, 0, rd);
        chk("ram_alias", rd, 32'hDEAD_BEEF);

        if (MIS_EN) begin
            step(1, 32'h0000_0012, 32'h1234_5678, 0, rd);
            step(0, 32'h0000_0010, 0, 0, rd);
            chk("mis_ram_kept", rd, 32'hDEAD_BEEF);
            step(0, A_STATUS, 0, 0, rd);
            chk("mis_sticky", rd & 32'h8, 32'h8);
            step(1, A_STATUS, 32'h8, 0, rd);
            step(0, A_STATUS, 0, 0, rd);
            chk("mis_cleared", rd, 32'h0000_0002);
        end

        // fill FIFO, overflow, clear
        for (int i = 1; i <= 8; i++) step(1, A_TX, 32'(i), 0, rd);
        step(0, A_STATUS, 0, 0, rd);
        chk("status_full", rd, 32'h0000_0081);
        step(1, A_TX, 32'h9, 0, rd);
        step(0, A_STATUS, 0, 0, rd);
        chk("status_ovf", rd, 32'h0000_0085);
        step(1, A_STATUS, 32'h4, 0, rd);
        step(0, A_STATUS, 0, 0, rd);
        chk("status_ovf_clr", rd, 32'h0000_0081);

        // push into full FIFO while popping
        step(1, A_TX, 32'hAA, 1, rd);
        collect = 1'b1;
        step(0, A_STATUS, 0, 0, rd);
        chk("status_push_pop", rd, 32'h0000_0081);
        for (int i = 0; i < 10; i++) step(0, A_STATUS, 0, 1, rd);
        collect = 1'b0;
        for (int i = 0; i < 7; i++) exp_drain[i] = 8'(i + 2);
        exp_drain[7] = 8'hAA;
        chk("drain_count", 32'(drained.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < drained.size()) chk("drain_byte", 32'(drained[i]), 32'(exp_drain[i]));
        end

        // cycle counter wrap and GPIO
        step(1, A_CYCLE, 32'hFFFF_FFFE, 0, rd);
        step(0, A_CYCLE, 0, 0, rd);
        chk("cycle_fffe", rd, 32'hFFFF_FFFE);
        step(0, A_CYCLE, 0, 0, rd);
        chk("cycle_ffff", rd, 32'hFFFF_FFFF);
        step(0, A_CYCLE, 0, 0, rd);
        chk("cycle_wrap", rd, 32'h0000_0000);
        step(1, A_GPIO, 32'h5A, 0, rd);
        step(0, A_GPIO, 0, 0, rd);
        chk("gpio_lit", bus.gpio_out, 32'h0000_005A);

        // reset mid-drain
        for (int i = 0; i < 3; i++) step(1, A_TX, 32'(8'h30 + i), 0, rd);
        step(0, A_STATUS, 0, 1, rd);
        do_reset();
        step(0, A_STATUS, 0, 0, rd);
        chk("status_post_rst", rd, 32'h0000_0002);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [31:0] a, d;
            logic [1:0] lo, off;
            logic [3:0] top;
            bit we, rdy;
            r = $urandom_range(0, 9);
            lo = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            if (r < 5) begin
                off = (r < 3) ? 2'd0 : 2'($urandom_range(1, 3));
                if (off == 2'd2 && $urandom_range(0, 3) != 0) off = 2'd1;
                a = {4'h8, 24'($urandom), off, lo};
            end else begin
                top = 4'($urandom_range(0, 15));
                if (top == 4'h8) top = 4'h0;
                a = {top, 26'($urandom), lo};
            end
            we  = ($urandom_range(0, 1) == 1);
            d   = $urandom;
            rdy = ($urandom_range(0, 9) < 4);
            step(we, a, d, rdy, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dbus_responder.md
Name: dbus_responder

Overview:
- Data-side responder for the pipelined core's memory-stage port: it decodes MemWriteM / ALUResultM / BM and returns ReadDataM in the same cycle.
- Address space has two regions:
  - word-addressed RAM;
  - MMIO page holding a byte-stream TX FIFO, status, a free-running cycle counter and a GPIO register.
- The FIFO drains over a valid/ready byte stream toward an external consumer, such as a UART serializer.

Parameters:
- RAM_WORDS, 256, RAM depth in 32-bit words; power of two, at least 4.
- FIFO_DEPTH, 8, TX FIFO depth in bytes; power of two, 2..16.
- MMIO_NIBBLE, 4'h8, value of address bits [31:28] that selects the MMIO page.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous, active-low reset.
- MemWriteM, input, 1, write strobe from the memory stage.
- ALUResultM, input, 32, byte address.
- BM, input, 32, write data.
- ReadDataM, output, 32, combinational read data.
- tx_valid, output, 1, FIFO head byte is valid.
- tx_data, output, 8, FIFO head byte.
- tx_ready, input, 1, consumer accepts the head byte.
- gpio_out, output, 32, GPIO register contents.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low; it asserts immediately and releases synchronously to the design.
- Reset values:
  - FIFO read/write pointers and count = 0, overflow sticky = 0.
  - cycle counter = 0, gpio_out = 0.
  - tx_valid = 0, tx_data = 0 (FIFO empty).
  - RAM contents are not reset.
- Decode: mmio_sel = (ALUResultM[31:28] == MMIO_NIBBLE); otherwise RAM is selected.
- RAM:
  - Index = ALUResultM[log2(RAM_WORDS)+1:2]; higher bits are ignored, so the RAM aliases/wraps.
  - Address bits [1:0] are ignored.
  - Write: whole word BM at the posedge when MemWriteM && !mmio_sel.
  - Read: asynchronous. ReadDataM = mem[index] in the same cycle. During a write cycle it shows the pre-write value.
- MMIO register select is offset ALUResultM[3:2]. Bits [27:4] are ignored, so registers alias across the page.
  - Offset 0, TXDATA:
    - Write pushes BM[7:0] when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
    - Otherwise the byte is dropped and overflow is set to 1.
    - Reads return 0.
  - Offset 1, STATUS:
    - Read layout: bit0 = full, bit1 = empty, bit2 = overflow, bits[8:4] = count (0..FIFO_DEPTH), all other bits 0.
    - Writing with BM[2] = 1 clears overflow.
    - If a clear and a new overflow collide in the same cycle, set wins.
  - Offset 2, CYCLE:
    - 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF -> 0.
    - A write loads BM; the value reads BM on the next cycle and increments from there.
    - Reads return the current value.
  - Offset 3, GPIO: write loads BM; read returns gpio_out.
- Stream side:
  - tx_valid = !empty; tx_data = head byte.
  - Pop on the posedge when tx_valid && tx_ready.
  - tx_data stays stable while tx_valid && !tx_ready.
- Simultaneous push and pop:
  - count unchanged; both pointers advance modulo FIFO_DEPTH.
  - When empty, no pop occurs (tx_valid = 0), so a push makes count = 1 and tx_valid = 1 on the next cycle. There is no fall-through.
- Latencies:
  - push -> tx_valid: 1 cycle.
  - register write -> readback: 1 cycle.
  - RAM read: 0 cycles.
- Reset during activity: queued bytes are discarded and tx_valid drops immediately. A write in the reset cycle has no effect on the registers (RAM may capture it; this is don't-care).

Optional Feature:
- Macro: DBUS_MISALIGN_CHECK_EN.
- With the macro defined:
  - Any access with ALUResultM[1:0] != 0 is flagged misaligned. Misaligned writes are suppressed for both RAM and MMIO, and misaligned reads return 32'h0.
  - A sticky bit, STATUS bit3, is set on a misaligned write and cleared by writing STATUS with BM[3] = 1.
- Without the macro: bits [1:0] are ignored everywhere and STATUS bit3 reads 0.

Test Plan:
- Release reset; read STATUS -> ReadDataM = 32'h0000_0002 (empty), tx_valid = 0; read CYCLE twice, 3 cycles apart -> values differ by 3.
- Write 32'hDEADBEEF to 0x0000_0010, then read 0x0000_0010 and alias 0x0000_0410 (RAM_WORDS = 256) -> both return 32'hDEADBEEF; during the write cycle ReadDataM shows the old value.
- tx_ready = 0; write bytes 0x01..0x09 to 0x8000_0000 -> after 8 pushes STATUS = 32'h0000_0081 (full, count 8); 9th byte dropped, bit2 set (32'h0000_0085); write STATUS with BM = 32'h4 -> overflow clears.
- FIFO full with tx_ready = 1 while pushing 0xAA -> push accepted, count stays 8; drained order is 0x02..0x08 then 0xAA.
- Write 32'hFFFF_FFFE to CYCLE -> reads 0xFFFFFFFE, 0xFFFFFFFF, then 0x00000000 on successive cycles; write 32'h5A to GPIO -> gpio_out = 32'h5A next cycle.
- Assert rst mid-drain with 3 bytes queued -> tx_valid falls immediately, gpio_out = 0; after release STATUS = 32'h0000_0002. With DBUS_MISALIGN_CHECK_EN: write to 0x0000_0012 -> RAM word at 0x10 unchanged and STATUS bit3 = 1.
